// File: rtl/instr_loader.sv
// Byte-stream instruction loader: packs little-endian bytes into 32-bit words,
// writes DEPTH words to instruction memory and keeps a wrapping checksum.
module instr_loader #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_byte,
  output logic              in_ready,
  output logic              load_en,
  output logic [ADDR_W-1:0] address,
  output logic [31:0]       load_inst,
  output logic              load_done,
  output logic [31:0]       checksum
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    COLLECT = 2'b01,
    WRITE   = 2'b10,
    DONE    = 2'b11
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  state_t            state_r;
  state_t            state_nx_s;
  logic              accept_s;
  logic              clear_s;
  logic [1:0]        byte_cnt_r;
  logic [ADDR_W-1:0] word_idx_r;
  logic [23:0]       asm_r;
  logic              in_ready_r;
  logic              load_en_r;
  logic              load_done_r;
  logic [ADDR_W-1:0] address_r;
  logic [31:0]       load_inst_r;
  logic [31:0]       checksum_r;

  // Next-state decode plus the byte-accept and image-clear strobes.
  always_comb begin
    state_nx_s = state_r;
    accept_s   = 1'b0;
    clear_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nx_s = COLLECT;
          clear_s    = 1'b1;
        end else begin
          state_nx_s = IDLE;
        end
      end
      COLLECT: begin
        if (in_valid && in_ready_r) begin
          accept_s = 1'b1;
          if (byte_cnt_r == 2'd3) begin
            state_nx_s = WRITE;
          end else begin
            state_nx_s = COLLECT;
          end
        end else begin
          state_nx_s = COLLECT;
        end
      end
      WRITE: begin
        if (word_idx_r == LAST_IDX) begin
          state_nx_s = DONE;
        end else begin
          state_nx_s = COLLECT;
        end
      end
      DONE: begin
        if (start) begin
          state_nx_s = COLLECT;
          clear_s    = 1'b1;
        end else begin
          state_nx_s = DONE;
        end
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Status flags are registered from the next state so they track it exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_r  <= 1'b0;
      load_en_r   <= 1'b0;
      load_done_r <= 1'b0;
    end else begin
      in_ready_r  <= (state_nx_s == COLLECT);
      load_en_r   <= (state_nx_s == WRITE);
      load_done_r <= (state_nx_s == DONE);
    end
  end

  // Word assembly, write-port registers, word index and checksum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt_r  <= 2'd0;
      word_idx_r  <= '0;
      asm_r       <= 24'd0;
      address_r   <= '0;
      load_inst_r <= 32'd0;
      checksum_r  <= 32'd0;
    end else if (clear_s) begin
      byte_cnt_r <= 2'd0;
      word_idx_r <= '0;
      checksum_r <= 32'd0;
    end else if (accept_s) begin
      byte_cnt_r <= byte_cnt_r + 2'd1;
      case (byte_cnt_r)
        2'd0: asm_r[7:0]   <= in_byte;
        2'd1: asm_r[15:8]  <= in_byte;
        2'd2: asm_r[23:16] <= in_byte;
        2'd3: begin
          // Top lane bypasses the assembly register straight into the write word.
          load_inst_r <= {in_byte, asm_r};
          address_r   <= word_idx_r;
        end
        default: asm_r <= asm_r;
      endcase
    end else if (state_r == WRITE) begin
      checksum_r <= checksum_r + load_inst_r;
      if (word_idx_r != LAST_IDX) begin
        word_idx_r <= word_idx_r + ADDR_W'(1);
      end
    end
  end

  assign in_ready  = in_ready_r;
  assign load_en   = load_en_r;
  assign load_done = load_done_r;
  assign address   = address_r;
  assign load_inst = load_inst_r;
  assign checksum  = checksum_r;

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: a full-size instance and a DEPTH=4 instance
// compared every cycle against a transaction-level model, plus literal expectations.
module tb_instr_loader;

  localparam int DEP0 = 256;
  localparam int AW0  = 8;
  localparam int DEP1 = 4;
  localparam int AW1  = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic       start_s[2];
  logic       in_valid_s[2];
  logic [7:0] in_byte_s[2];
  logic       in_ready_s[2];
  logic       load_en_s[2];
  logic       load_done_s[2];
  logic [31:0] load_inst_s[2];
  logic [31:0] checksum_s[2];
  logic [AW0-1:0] addr0;
  logic [AW1-1:0] addr1;
  logic [7:0] addr_s[2];

  assign addr_s[0] = addr0;
  assign addr_s[1] = {6'd0, addr1};

  always #5 clk = ~clk;

  instr_loader #(.DEPTH(DEP0), .ADDR_W(AW0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_s[0]), .in_valid(in_valid_s[0]),
    .in_byte(in_byte_s[0]), .in_ready(in_ready_s[0]), .load_en(load_en_s[0]),
    .address(addr0), .load_inst(load_inst_s[0]), .load_done(load_done_s[0]),
    .checksum(checksum_s[0])
  );

  instr_loader #(.DEPTH(DEP1), .ADDR_W(AW1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_s[1]), .in_valid(in_valid_s[1]),
    .in_byte(in_byte_s[1]), .in_ready(in_ready_s[1]), .load_en(load_en_s[1]),
    .address(addr1), .load_inst(load_inst_s[1]), .load_done(load_done_s[1]),
    .checksum(checksum_s[1])
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input int i, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s[%0d]: got 0x%08h, expected 0x%08h at %0t", nm, i, got, exp, $time);
    end
  endtask

  function automatic int dep(input int i);
    return (i == 0) ? DEP0 : DEP1;
  endfunction

  // Transaction-level model: loading flag, byte count, pending write, running sum.
  bit          m_load[2];
  bit          m_wr[2];
  bit          m_done[2];
  int          m_nb[2];
  int          m_idx[2];
  logic [31:0] m_word[2];
  logic [31:0] m_inst[2];
  logic [31:0] m_sum[2];
  logic [7:0]  m_addr[2];
  int          pulses[2];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_load[i] <= 1'b0; m_wr[i] <= 1'b0; m_done[i] <= 1'b0;
        m_nb[i] <= 0; m_idx[i] <= 0; m_word[i] <= 32'd0;
        m_inst[i] <= 32'd0; m_sum[i] <= 32'd0; m_addr[i] <= 8'd0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (m_wr[i]) begin
          m_wr[i]  <= 1'b0;
          m_sum[i] <= m_sum[i] + m_inst[i];
          if (m_idx[i] == dep(i) - 1) begin
            m_done[i] <= 1'b1;
            m_load[i] <= 1'b0;
          end else begin
            m_idx[i] <= m_idx[i] + 1;
          end
        end else if (m_load[i]) begin
          if (in_valid_s[i]) begin
            if (m_nb[i] == 3) begin
              m_inst[i] <= m_word[i] | (32'(in_byte_s[i]) << 24);
              m_addr[i] <= 8'(m_idx[i]);
              m_wr[i]   <= 1'b1;
              m_nb[i]   <= 0;
              m_word[i] <= 32'd0;
            end else begin
              m_word[i] <= m_word[i] | (32'(in_byte_s[i]) << (8 * m_nb[i]));
              m_nb[i]   <= m_nb[i] + 1;
            end
          end
        end else if (start_s[i]) begin
          m_load[i] <= 1'b1; m_done[i] <= 1'b0; m_idx[i] <= 0;
          m_nb[i] <= 0; m_sum[i] <= 32'd0; m_word[i] <= 32'd0;
        end
      end
    end
  end

  // Compare process: every output of both instances against the model each cycle.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      chk("in_ready",  i, 32'(in_ready_s[i]),  32'(m_load[i] && !m_wr[i]));
      chk("load_en",   i, 32'(load_en_s[i]),   32'(m_wr[i]));
      chk("address",   i, 32'(addr_s[i]),      32'(m_addr[i]));
      chk("load_inst", i, load_inst_s[i],      m_inst[i]);
      chk("load_done", i, 32'(load_done_s[i]), 32'(m_done[i]));
      chk("checksum",  i, checksum_s[i],       m_sum[i]);
      if (load_en_s[i]) pulses[i] = pulses[i] + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int i);
    start_s[i] = 1'b1;
    tick();
    start_s[i] = 1'b0;
  endtask

  task automatic send_byte(input int i, input logic [7:0] b, input bit gap);
    bit acc;
    int n;
    acc = 1'b0;
    n = 0;
    in_valid_s[i] = 1'b1;
    in_byte_s[i]  = b;
    while (!acc && n < 20) begin
      @(negedge clk);
      acc = in_ready_s[i];
      tick();
      n++;
    end
    if (!acc) chk("byte_timeout", i, 32'(acc), 32'd1);
    if (gap) begin
      in_valid_s[i] = 1'b0;
      tick();
    end
  endtask

  task automatic send_word(input int i, input logic [31:0] w, input bit gap);
    for (int k = 0; k < 4; k++) send_byte(i, w[8*k +: 8], gap);
  endtask

  task automatic check_reset_outputs(input string nm);
    for (int i = 0; i < 2; i++) begin
      chk({nm, "_in_ready"},  i, 32'(in_ready_s[i]),  32'd0);
      chk({nm, "_load_en"},   i, 32'(load_en_s[i]),   32'd0);
      chk({nm, "_address"},   i, 32'(addr_s[i]),      32'd0);
      chk({nm, "_load_inst"}, i, load_inst_s[i],      32'd0);
      chk({nm, "_load_done"}, i, 32'(load_done_s[i]), 32'd0);
      chk({nm, "_checksum"},  i, checksum_s[i],       32'd0);
    end
  endtask

  task automatic full_image(input bit gap, input string nm);
    int p0;
    pulse_start(0);
    chk({nm, "_start_done"}, 0, 32'(load_done_s[0]), 32'd0);
    chk({nm, "_start_sum"},  0, checksum_s[0],       32'd0);
    p0 = pulses[0];
    for (int k = 0; k < 256; k++) begin
      send_word(0, {24'hDEADBE, 8'(k)}, gap);
      if (k == 0) begin
        if (gap) begin
          chk({nm, "_w0_addr"}, 0, 32'(addr_s[0]), 32'd0);
        end else begin
          chk({nm, "_w0_en"},   0, 32'(load_en_s[0]), 32'd1);
          chk({nm, "_w0_addr"}, 0, 32'(addr_s[0]),    32'd0);
          chk({nm, "_w0_inst"}, 0, load_inst_s[0],    32'hDEADBE00);
        end
      end
    end
    in_valid_s[0] = 1'b0;
    if (!gap) tick();
    chk({nm, "_pulses"},    0, 32'(pulses[0] - p0), 32'd256);
    chk({nm, "_done"},      0, 32'(load_done_s[0]), 32'd1);
    chk({nm, "_last_addr"}, 0, 32'(addr_s[0]),      32'h000000FF);
    chk({nm, "_sum"},       0, checksum_s[0],       32'hADBE7F80);
    chk({nm, "_model_sum"}, 0, m_sum[0],            32'hADBE7F80);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      start_s[i] = 1'b0; in_valid_s[i] = 1'b0; in_byte_s[i] = 8'd0; pulses[i] = 0;
    end
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) tick();
    check_reset_outputs("rst");
    rst_n = 1'b1;

    // in_valid in IDLE is ignored
    in_valid_s[0] = 1'b1;
    in_byte_s[0]  = 8'hAA;
    repeat (3) begin
      tick();
      chk("idle_ready", 0, 32'(in_ready_s[0]), 32'd0);
    end
    in_valid_s[0] = 1'b0;

    pulse_start(0);
    chk("start_ready", 0, 32'(in_ready_s[0]), 32'd1);
    send_word(0, 32'h12345678, 1'b0);
    in_valid_s[0] = 1'b0;
    chk("w0_load_en",   0, 32'(load_en_s[0]), 32'd1);
    chk("w0_address",   0, 32'(addr_s[0]),    32'd0);
    chk("w0_load_inst", 0, load_inst_s[0],    32'h12345678);

    // start during WRITE and during COLLECT is ignored
    pulse_start(0);
    pulse_start(0);
    for (int k = 1; k < 5; k++) send_word(0, 32'hA0000000 + 32'(k), 1'b0);
    send_byte(0, 8'h11, 1'b0);
    send_byte(0, 8'h22, 1'b0);
    in_valid_s[0] = 1'b0;
    chk("pre_rst_addr", 0, 32'(addr_s[0]), 32'd4);

    // asynchronous reset mid-word
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async_rst");
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    full_image(1'b0, "b2b");
    full_image(1'b1, "gap");

    // DEPTH=4, all-ones last address, checksum wrap
    pulse_start(1);
    send_word(1, 32'hFFFFFFFF, 1'b0);
    send_word(1, 32'h00000001, 1'b0);
    send_word(1, 32'h00000002, 1'b0);
    send_word(1, 32'h00000003, 1'b0);
    in_valid_s[1] = 1'b0;
    tick();
    chk("d4_done", 1, 32'(load_done_s[1]), 32'd1);
    chk("d4_sum",  1, checksum_s[1],       32'h00000005);
    chk("d4_addr", 1, 32'(addr_s[1]),      32'd3);
    in_valid_s[1] = 1'b1;
    in_byte_s[1]  = 8'h55;
    repeat (2) begin
      tick();
      chk("done_ready", 1, 32'(in_ready_s[1]), 32'd0);
    end
    in_valid_s[1] = 1'b0;
    chk("d4_sum_held", 1, checksum_s[1], 32'h00000005);
    pulse_start(1);
    chk("d4_restart_done", 1, 32'(load_done_s[1]), 32'd0);
    chk("d4_restart_sum",  1, checksum_s[1],       32'd0);
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_loader.md
INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 Parameter DEPTH, default 256, number of 32-bit words loaded per program image.
REQ-002 Parameter ADDR_W, default 8, width of word address; DEPTH SHALL be <= 2**ADDR_W.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 start  input  1  single-cycle request to begin loading an image.
REQ-006 in_valid  input  1  byte-stream source has a byte on in_byte.
REQ-007 in_byte  input  8  program byte; words arrive little-endian, byte 0 first.
REQ-008 in_ready  output  1  loader accepts in_byte this cycle.
REQ-009 load_en  output  1  write strobe to instruction memory, one cycle per word.
REQ-010 address  output  ADDR_W  word address for the current write.
REQ-011 load_inst  output  32  word to write.
REQ-012 load_done  output  1  image complete; held until next start or reset.
REQ-013 checksum  output  32  wrapping sum of all words written in current image.

Function
REQ-014 States: IDLE, COLLECT, WRITE, DONE; the state machine SHALL take no other states.
REQ-015 Byte transfer occurs on a rising edge where in_valid && in_ready; no other condition moves data.
REQ-016 in_ready SHALL be 1 only in COLLECT; it SHALL be 0 in IDLE, WRITE and DONE.
REQ-017 IDLE -> COLLECT on start=1; word index, byte count and checksum cleared to 0 on that edge.
REQ-018 COLLECT: the 2-bit byte count selects the lane; byte n goes to bits [8n+7:8n] of the assembly register.
REQ-019 COLLECT -> WRITE on the edge accepting byte 3; the byte count wraps to 0.
REQ-020 WRITE lasts exactly one cycle: load_en=1, address=word index, load_inst=assembled word.
REQ-021 Outside WRITE, load_en SHALL be 0; address and load_inst hold their last values.
REQ-022 On the WRITE exit edge, checksum <= checksum + load_inst (mod 2**32).
REQ-023 WRITE -> DONE if word index == DEPTH-1; otherwise WRITE -> COLLECT with word index + 1.
REQ-024 Latency: load_en SHALL assert in the cycle immediately after the 4th byte of a word is accepted.
REQ-025 Minimum throughput is 5 cycles per word; in_valid gaps stall COLLECT without losing bytes.
REQ-026 DONE: load_done=1 and checksum held; DONE -> COLLECT on start=1 with the clears of REQ-017 and load_done -> 0 on the same edge.
REQ-027 start SHALL be ignored in COLLECT and WRITE.
REQ-028 in_valid in IDLE or DONE SHALL be ignored and no byte consumed.
REQ-029 The word index SHALL never exceed DEPTH-1; with DEPTH=2**ADDR_W the last address is all-ones and no wrap write occurs.

Reset
REQ-030 rst_n=0 SHALL immediately force state IDLE, in_ready=0, load_en=0, address=0, load_inst=0, load_done=0, checksum=0, byte count=0, word index=0.
REQ-031 Reset mid-load SHALL abandon the partial word and image; no load_en pulse follows until a new start.
REQ-032 Exit from reset SHALL be synchronous to clk; the first start is honoured at the earliest on the first rising edge with rst_n=1.

Verification
REQ-033 Reset then start, stream 1024 bytes forming words {24'hDEADBE, idx[7:0]} back-to-back -> 256 load_en pulses, address 0x00..0xFF in order, load_done=1 after the write at 0xFF.
REQ-034 Word 0 bytes 0x78,0x56,0x34,0x12 -> load_en with address=0, load_inst=0x12345678 in the cycle after byte 0x12 is accepted.
REQ-035 in_valid toggled 1/0 every cycle during a full image -> identical memory contents and checksum to REQ-033, no dropped or duplicated bytes.
REQ-036 DEPTH=4, words 0xFFFFFFFF,1,2,3 -> checksum=0x00000005 at load_done; second start -> load_done=0, checksum=0 on that edge.
REQ-037 rst_n pulsed low after 2 bytes of word 5 -> all outputs at reset values; new start loads from address 0 with no stale bytes.
REQ-038 start asserted during COLLECT, in_valid asserted in IDLE -> no state change, no byte consumed, in_ready stays 0 in IDLE.
